// File: rtl/exp_pkg.sv
// Shared constants for the exponential pipeline: Q8.24 format, rounding constant
// and the stage-1 state encoding.
package exp_pkg;

  localparam int EXP_WIDTH      = 32;
  localparam int EXP_FRAC_BITS  = 24;
  localparam int EXP_DIGIT_BITS = 16;

  localparam logic [EXP_WIDTH-1:0] EXP_ONE   = EXP_WIDTH'(1) << EXP_FRAC_BITS;
  localparam logic [EXP_WIDTH-1:0] EXP_ROUND = EXP_WIDTH'(1) << (EXP_FRAC_BITS - 1);

  typedef enum logic [1:0] {
    S1_IDLE = 2'd0,
    S1_MUL  = 2'd1,
    S1_DONE = 2'd2
  } s1_state_t;

endpackage

// File: rtl/stage_1_fifo2.sv
// Two-entry register buffer in front of the stage-1 multiplier. Entry 0 is the head;
// pushes into a full buffer without a same-cycle pop are dropped and flagged sticky.
module stage_1_fifo2 #(
  parameter int DW = 56
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o,
  output logic          empty_o,
  output logic          overflow_o
);

  logic [DW-1:0] mem0_q, mem1_q;
  logic [1:0]    count_q, count_d;
  logic          overflow_q;
  logic          full, accept, drop;
  logic [1:0]    wr_idx;

  always_comb begin
    full    = (count_q == 2'd2);
    accept  = push_i && (!full || pop_i);
    drop    = push_i && full && !pop_i;
    // Slot the push lands in, after any same-cycle pop has shifted entry 1 down.
    wr_idx  = count_q - {1'b0, pop_i};
    count_d = count_q;
    if (accept && !pop_i) begin
      count_d = count_q + 2'd1;
    end else if (!accept && pop_i) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q     <= '0;
      mem1_q     <= '0;
      count_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      if (pop_i) begin
        mem0_q <= mem1_q;
      end
      if (accept) begin
        if (wr_idx == 2'd0) begin
          mem0_q <= push_data_i;
        end else begin
          mem1_q <= push_data_i;
        end
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign head_o     = mem0_q;
  assign count_o    = count_q;
  assign empty_o    = (count_q == 2'd0);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/stage_1_control.sv
// Stage-1 controller: computes lut * (1 + frac) in Q8.24 with a digit-serial multiply,
// round-half-up and saturation, and presents the result on a valid/ready port.
module stage_1_control
  import exp_pkg::*;
#(
  parameter int WIDTH      = EXP_WIDTH,
  parameter int FRAC_BITS  = EXP_FRAC_BITS,
  parameter int DIGIT_BITS = EXP_DIGIT_BITS
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [WIDTH-1:0] s0_lut,
  input  logic [WIDTH-1:0] s0_frac,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [1:0]       fifo_count,
  output logic             overflow
);

  localparam int N_DIG = WIDTH / DIGIT_BITS;
  localparam int AW    = 2 * WIDTH + 1;
  localparam int KW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int EW    = WIDTH + FRAC_BITS;
  localparam logic [WIDTH:0]  ONE_M   = (WIDTH + 1)'(1) << FRAC_BITS;
  localparam logic [AW-1:0]   ROUND_C = AW'(1) << (FRAC_BITS - 1);

  // Output handshake: a result is transferred on a rising edge where out_valid and
  // out_ready are both high; out_data/out_sat stay stable while out_valid waits.

  s1_state_t        state_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] l_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [KW-1:0]    k_q;
  logic             out_valid_q, out_sat_q;
  logic [WIDTH-1:0] out_data_q;

  logic                 pop, fifo_empty;
  logic [EW-1:0]        head;
  logic [WIDTH-1:0]     head_lut;
  logic [FRAC_BITS-1:0] head_frac;
  logic                 unused_frac_hi;

  logic [WIDTH-1:0]      l_shift;
  logic [DIGIT_BITS-1:0] digit;
  logic [AW-1:0]         partial, r;
  logic                  sat;

  assign unused_frac_hi = ^s0_frac[WIDTH-1:FRAC_BITS];

  stage_1_fifo2 #(.DW(EW)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (rst_n),
    .push_i      (s0_valid),
    .push_data_i ({s0_lut, s0_frac[FRAC_BITS-1:0]}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .overflow_o  (overflow)
  );

  assign head_lut  = head[EW-1:FRAC_BITS];
  assign head_frac = head[FRAC_BITS-1:0];
  assign pop = !fifo_empty && ((state_q == S1_IDLE) || (state_q == S1_DONE && out_ready));

  always_comb begin
    l_shift = l_q >> (int'(k_q) * DIGIT_BITS);
    digit   = l_shift[DIGIT_BITS-1:0];
    partial = (AW'(m_q) * AW'(digit)) << (int'(k_q) * DIGIT_BITS);
    acc_d   = acc_q + partial;
    r       = (acc_d + ROUND_C) >> FRAC_BITS;
    sat     = |r[AW-1:WIDTH];
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S1_IDLE;
      m_q         <= '0;
      l_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // Operand load is shared by IDLE and the back-to-back path out of DONE.
      if (pop) begin
        m_q   <= ONE_M + (WIDTH + 1)'(head_frac);
        l_q   <= head_lut;
        acc_q <= '0;
        k_q   <= '0;
      end
      case (state_q)
        S1_IDLE: begin
          if (pop) state_q <= S1_MUL;
        end
        S1_MUL: begin
          acc_q <= acc_d;
          k_q   <= k_q + KW'(1);
          if (k_q == KW'(N_DIG - 1)) begin
            out_data_q  <= sat ? '1 : r[WIDTH-1:0];
            out_sat_q   <= sat;
            out_valid_q <= 1'b1;
            state_q     <= S1_DONE;
          end
        end
        S1_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= pop ? S1_MUL : S1_IDLE;
          end
        end
        default: state_q <= S1_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_stage_1_control.sv
// Directed bench for stage_1_control: vector table for arithmetic and latency, plus
// hand-written back-pressure, full push/pop, and async reset sequences.
module tb_stage_1_control;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         s0_valid;
  logic [W-1:0] s0_lut;
  logic [W-1:0] s0_frac;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic [1:0]   fifo_count;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results as {sat, data}.
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] lut;
    logic [W-1:0] frac;
    logic [W-1:0] exp_data;
    logic         exp_sat;
  } vec_t;

  vec_t vecs[10];

  always #5 CLK = ~CLK;

  stage_1_control dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .s0_valid   (s0_valid),
    .s0_lut     (s0_lut),
    .s0_frac    (s0_frac),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after an edge; the pulse is sampled on the next edge.
  task automatic push(input logic [W-1:0] lut, input logic [W-1:0] frac);
    s0_valid = 1'b1;
    s0_lut   = lut;
    s0_frac  = frac;
    tick();
    s0_valid = 1'b0;
    s0_lut   = '0;
    s0_frac  = '0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Expects out_ready=1; every observed valid is transferred on the following edge.
  task automatic collect(input int n_exp, input int budget);
    int got = 0;
    int cyc = 0;
    logic [W:0] e;
    while (got < n_exp && cyc < budget) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("collect data #%0d", got), 64'(out_data), 64'(e[W-1:0]));
          check($sformatf("collect sat #%0d", got), 64'(out_sat), 64'(e[W]));
        end
        got++;
      end
      tick();
      cyc++;
    end
    check("collect result count", 64'(got), 64'(n_exp));
  endtask

  initial begin
    int n;
    int seen;

    rst_n     = 1'b0;
    s0_valid  = 1'b0;
    s0_lut    = '0;
    s0_frac   = '0;
    out_ready = 1'b0;

    vecs[0] = '{32'h0200_0000, 32'h0080_0000, 32'h0300_0000, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0080_0000, 32'h0000_0002, 1'b0};
    vecs[2] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h00FF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h0100_0000, 32'h0040_0000, 32'h0140_0000, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h00FF_FFFF, 32'hFFFF_FF7E, 1'b0};
    vecs[6] = '{32'h0080_0000, 32'h0000_0001, 32'h0080_0001, 1'b0};
    vecs[7] = '{32'h0100_0000, 32'hFF00_0000, 32'h0100_0000, 1'b0};
    vecs[8] = '{32'hAAAA_AAAA, 32'h0080_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[9] = '{32'hAAAA_AAAB, 32'h0080_0000, 32'hFFFF_FFFF, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_sat", 64'(out_sat), 64'd0);
    check("reset fifo_count", 64'(fifo_count), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table: push sampled on edge 0, result registered on edge 3, taken on edge 4.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].lut, vecs[i].frac);
      wait_valid(20, n);
      check($sformatf("v%0d latency", i), 64'(n + 1), 64'd4);
      check($sformatf("v%0d data", i), 64'(out_data), 64'(vecs[i].exp_data));
      check($sformatf("v%0d sat", i), 64'(out_sat), 64'(vecs[i].exp_sat));
      tick();
      check($sformatf("v%0d valid one cycle", i), 64'(out_valid), 64'd0);
    end

    // Back-pressure: four pushes 4 cycles apart while the consumer stalls.
    out_ready = 1'b0;
    push(32'h0100_0000, 32'h0000_0000);
    repeat (3) tick();
    check("bp A valid", 64'(out_valid), 64'd1);
    check("bp A data", 64'(out_data), 64'h0100_0000);
    push(32'h0200_0000, 32'h0080_0000);
    repeat (3) tick();
    push(32'h0300_0000, 32'h0040_0000);
    check("bp count after push 3", 64'(fifo_count), 64'd2);
    check("bp overflow before drop", 64'(overflow), 64'd0);
    check("bp A held", 64'(out_data), 64'h0100_0000);
    repeat (3) tick();
    push(32'h0500_0000, 32'h0000_0000);
    check("bp overflow after drop", 64'(overflow), 64'd1);
    check("bp count after drop", 64'(fifo_count), 64'd2);
    check("bp A still held", 64'(out_data), 64'h0100_0000);
    check("bp A still valid", 64'(out_valid), 64'd1);
    exp_q.push_back({1'b0, 32'h0100_0000});
    exp_q.push_back({1'b0, 32'h0300_0000});
    exp_q.push_back({1'b0, 32'h03C0_0000});
    out_ready = 1'b1;
    collect(3, 40);
    check("bp drained count", 64'(fifo_count), 64'd0);
    check("bp overflow sticky", 64'(overflow), 64'd1);
    check("bp queue empty", 64'(exp_q.size()), 64'd0);

    // Async reset while the FSM is in MUL with one entry still buffered.
    push(32'h0100_0000, 32'h0000_0000);
    push(32'h0200_0000, 32'h0000_0000);
    check("ar setup count", 64'(fifo_count), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar out_valid", 64'(out_valid), 64'd0);
    check("ar out_data", 64'(out_data), 64'd0);
    check("ar out_sat", 64'(out_sat), 64'd0);
    check("ar fifo_count", 64'(fifo_count), 64'd0);
    check("ar overflow", 64'(overflow), 64'd0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    check("ar no valid without push", 64'(seen), 64'd0);
    check("ar count stays 0", 64'(fifo_count), 64'd0);
    push(32'h0400_0000, 32'h0080_0000);
    wait_valid(20, n);
    check("ar fresh latency", 64'(n + 1), 64'd4);
    check("ar fresh data", 64'(out_data), 64'h0600_0000);
    tick();

    // Push and pop in the same cycle while the buffer is full.
    out_ready = 1'b0;
    push(32'h0100_0000, 32'h0080_0000);
    push(32'h0200_0000, 32'h0040_0000);
    push(32'h0300_0000, 32'h0000_0000);
    tick();
    check("pp full count", 64'(fifo_count), 64'd2);
    check("pp E valid", 64'(out_valid), 64'd1);
    exp_q.push_back({1'b0, 32'h0180_0000});
    exp_q.push_back({1'b0, 32'h0280_0000});
    exp_q.push_back({1'b0, 32'h0300_0000});
    exp_q.push_back({1'b0, 32'h0000_0002});
    s0_valid  = 1'b1;
    s0_lut    = 32'h0000_0001;
    s0_frac   = 32'h0080_0000;
    out_ready = 1'b1;
    begin
      logic [W:0] e;
      e = exp_q.pop_front();
      check("pp E data", 64'(out_data), 64'(e[W-1:0]));
    end
    tick();
    s0_valid = 1'b0;
    s0_lut   = '0;
    s0_frac  = '0;
    check("pp count stays 2", 64'(fifo_count), 64'd2);
    check("pp no overflow", 64'(overflow), 64'd0);
    collect(3, 40);
    check("pp drained count", 64'(fifo_count), 64'd0);
    check("pp queue empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
